board_input_entry: RTL and testbench

Board-side input path: the counterpart of the register-to-HEX display path. It turns raw pushbuttons and slide switches into 16-bit words written into the processor register file. Hex digits are entered one nibble at a time from SW[3:0] and shown live via entry_value. A committed word is sent to the datapath register file over a held-request/ack write handshake.

---
 rtl/board_io_pkg.sv | 24 ++
 rtl/key_debounce.sv | 48 ++++
 rtl/board_input_entry.sv | 143 ++++++++++++++
 tb/tb_board_input_entry.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_io_pkg.sv
// Shared definitions for the board input path: key indices, entry FSM states
// and the default debounce interval.
package board_io_pkg;

   localparam int KEY_LOAD   = 0;
   localparam int KEY_COMMIT = 1;
   localparam int KEY_CLEAR  = 2;
   localparam int NUM_KEYS   = 3;

   // 5 ms at 50 MHz
   localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ENTRY = 2'd1,
      WRITE = 2'd2
   } entry_state_t;

   // Nibble counter increment that sticks at the maximum digit count.
   function automatic logic [2:0] sat_inc(input logic [2:0] count, input logic [2:0] max_count);
      sat_inc = (count >= max_count) ? max_count : count + 3'd1;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: 2-flop synchroniser, stability counter and a single-cycle
// pulse on each accepted press (stable level going 1 -> 0).
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clk,
   input  logic reset,
   input  logic i_key_n,
   output logic o_press
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic             r_sync1;
   logic             r_sync2;
   logic             r_stable;
   logic [CNT_W-1:0] r_cnt;
   logic             r_press;
   logic             w_settled;

   assign w_settled = (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
   assign o_press   = r_press;

   // Synchroniser and stable level come out of reset as "released" (high).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1  <= 1'b1;
         r_sync2  <= 1'b1;
         r_stable <= 1'b1;
         r_cnt    <= '0;
         r_press  <= 1'b0;
      end else begin
         r_sync1 <= i_key_n;
         r_sync2 <= r_sync1;
         r_press <= 1'b0;
         if (r_sync2 == r_stable) begin
            r_cnt <= '0;
         end else if (w_settled) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
            r_press  <= r_stable & ~r_sync2;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/board_input_entry.sv
// Board-side hex entry: debounced keys shift switch nibbles into a word and
// commit it to the register file over a held-request/ack write handshake.
module board_input_entry
   import board_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int DATA_WIDTH      = 16,
   parameter int ADDR_WIDTH      = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [2:0]              key_n,
   input  logic [ADDR_WIDTH+3:0]   sw,
   output logic [DATA_WIDTH-1:0]   entry_value,
   output logic [2:0]              nibble_count,
   output logic                    busy,
   output logic                    wr_en,
   output logic [ADDR_WIDTH-1:0]   wr_addr,
   output logic [DATA_WIDTH-1:0]   wr_data,
   input  logic                    wr_ack
);

   localparam logic [2:0] MAX_NIBBLES = 3'(DATA_WIDTH / 4);

   logic [NUM_KEYS-1:0]   w_press;
   logic [ADDR_WIDTH+3:0] r_sw_meta;
   logic [ADDR_WIDTH+3:0] r_sw_sync;

   entry_state_t          r_state;
   logic [DATA_WIDTH-1:0] r_entry;
   logic [2:0]            r_count;
   logic                  r_busy;
   logic                  r_wr_en;
   logic [ADDR_WIDTH-1:0] r_wr_addr;
   logic [DATA_WIDTH-1:0] r_wr_data;

   entry_state_t          w_state_next;
   logic [DATA_WIDTH-1:0] w_entry_next;
   logic [2:0]            w_count_next;
   logic                  w_busy_next;
   logic                  w_wr_en_next;
   logic [ADDR_WIDTH-1:0] w_wr_addr_next;
   logic [DATA_WIDTH-1:0] w_wr_data_next;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
         key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_key_debounce (
            .clk     (clk),
            .reset   (reset),
            .i_key_n (key_n[gi]),
            .o_press (w_press[gi])
         );
      end
   endgenerate

   // Switches are only synchronised; they are read when a key event fires.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sw_meta <= '0;
         r_sw_sync <= '0;
      end else begin
         r_sw_meta <= sw;
         r_sw_sync <= r_sw_meta;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_entry   <= '0;
         r_count   <= '0;
         r_busy    <= 1'b0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else begin
         r_state   <= w_state_next;
         r_entry   <= w_entry_next;
         r_count   <= w_count_next;
         r_busy    <= w_busy_next;
         r_wr_en   <= w_wr_en_next;
         r_wr_addr <= w_wr_addr_next;
         r_wr_data <= w_wr_data_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_entry_next   = r_entry;
      w_count_next   = r_count;
      w_busy_next    = r_busy;
      w_wr_en_next   = r_wr_en;
      w_wr_addr_next = r_wr_addr;
      w_wr_data_next = r_wr_data;

      case (r_state)
         IDLE, ENTRY: begin
            // CLEAR outranks COMMIT outranks LOAD; losers in the same cycle are dropped.
            if (w_press[KEY_CLEAR]) begin
               w_entry_next = '0;
               w_count_next = '0;
               w_state_next = IDLE;
            end else if (w_press[KEY_COMMIT]) begin
               if (r_count != 3'd0) begin
                  w_wr_en_next   = 1'b1;
                  w_wr_addr_next = r_sw_sync[ADDR_WIDTH+3:4];
                  w_wr_data_next = r_entry;
                  w_busy_next    = 1'b1;
                  w_state_next   = WRITE;
               end
            end else if (w_press[KEY_LOAD]) begin
               w_entry_next = {r_entry[DATA_WIDTH-5:0], r_sw_sync[3:0]};
               w_count_next = sat_inc(r_count, MAX_NIBBLES);
               w_state_next = ENTRY;
            end
         end
         WRITE: begin
            // Request stays up untouched until the register file acknowledges.
            if (wr_ack) begin
               w_wr_en_next = 1'b0;
               w_busy_next  = 1'b0;
               w_entry_next = '0;
               w_count_next = '0;
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   assign entry_value  = r_entry;
   assign nibble_count = r_count;
   assign busy         = r_busy;
   assign wr_en        = r_wr_en;
   assign wr_addr      = r_wr_addr;
   assign wr_data      = r_wr_data;

endmodule

// File: tb/tb_board_input_entry.sv
// Randomised bench for board_input_entry: a nibble-queue model predicts the
// displayed word and writes; a monitor checks every write against a scoreboard.
module tb_board_input_entry;
   import board_io_pkg::*;

   localparam int DB = 4;
   localparam int DW = 16;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [2:0]    key_n = 3'b111;
   logic [AW+3:0] sw = '0;
   logic          wr_ack = 1'b0;
   logic [DW-1:0] entry_value;
   logic [2:0]    nibble_count;
   logic          busy;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;

   board_input_entry #(
      .DEBOUNCE_CYCLES (DB),
      .DATA_WIDTH      (DW),
      .ADDR_WIDTH      (AW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .key_n        (key_n),
      .sw           (sw),
      .entry_value  (entry_value),
      .nibble_count (nibble_count),
      .busy         (busy),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .wr_ack       (wr_ack)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int            len;   // expected wr_en cycles, -1 when not timed
   } wr_t;

   int          checks = 0;
   int          errors = 0;
   int unsigned nib_q[$];
   wr_t         exp_q[$];
   bit          model_busy = 1'b0;
   int          ack_delay = 0;
   bit          ack_hold = 1'b0;
   bit          ack_force = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] model_entry();
      logic [DW-1:0] v = '0;
      foreach (nib_q[i]) v = (v << 4) | DW'(nib_q[i]);
      return v;
   endfunction

   // Reference behaviour of one simultaneous key press (mask bit per key).
   task automatic model_press(input logic [2:0] keys, input logic [3:0] nib, input logic [AW-1:0] addr);
      wr_t w;
      if (model_busy) return;
      if (keys[KEY_CLEAR]) begin
         nib_q.delete();
      end else if (keys[KEY_COMMIT]) begin
         if (nib_q.size() > 0) begin
            w.addr = addr;
            w.data = model_entry();
            w.len  = ack_hold ? -1 : ack_delay + 1;
            exp_q.push_back(w);
            if (ack_hold) model_busy = 1'b1;
            else nib_q.delete();
         end
      end else if (keys[KEY_LOAD]) begin
         nib_q.push_back(int'(nib));
         if (nib_q.size() > DW / 4) void'(nib_q.pop_front());
      end
   endtask

   task automatic check_entry(input string tag);
      check({tag, "_entry"}, 32'(entry_value), 32'(model_entry()));
      check({tag, "_count"}, 32'(nibble_count), nib_q.size());
   endtask

   task automatic press(input logic [2:0] keys, input logic [3:0] nib, input logic [AW-1:0] addr);
      @(negedge clk);
      model_press(keys, nib, addr);
      sw    = {addr, nib};
      key_n = ~keys;
      repeat (12) @(negedge clk);
      key_n = 3'b111;
      repeat (10) @(negedge clk);
      $display("press keys=%b sw=%0d/%h entry=%h count=%0d", keys, addr, nib, entry_value, nibble_count);
      check_entry("press");
   endtask

   // Acknowledge driver: raises wr_ack after ack_delay cycles of wr_en.
   initial begin
      int wc = 0;
      forever begin
         @(negedge clk);
         if (ack_force) begin
            wr_ack = 1'b1;
         end else if (wr_en && !ack_hold && !reset) begin
            if (wc == ack_delay) wr_ack = 1'b1;
            else begin
               wr_ack = 1'b0;
               wc++;
            end
         end else begin
            wr_ack = 1'b0;
            wc = 0;
         end
      end
   end

   // Write monitor: pops the scoreboard on each new request and checks it is held.
   initial begin
      bit  prev = 1'b0;
      wr_t cur;
      int  len = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev = 1'b0;
         end else if (wr_en) begin
            if (!prev) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_write: got addr %0d data 0x%0h expected no write", wr_addr, wr_data);
                  cur.addr = wr_addr;
                  cur.data = wr_data;
                  cur.len  = -1;
               end else begin
                  cur = exp_q.pop_front();
                  $display("write addr=%0d data=%h", wr_addr, wr_data);
                  check("wr_addr", 32'(wr_addr), 32'(cur.addr));
                  check("wr_data", 32'(wr_data), 32'(cur.data));
               end
               len = 1;
            end else begin
               check("wr_addr_hold", 32'(wr_addr), 32'(cur.addr));
               check("wr_data_hold", 32'(wr_data), 32'(cur.data));
               len++;
            end
            check("busy_in_write", 32'(busy), 32'd1);
            prev = 1'b1;
         end else begin
            if (prev && cur.len >= 0) check("wr_len", len, cur.len);
            prev = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      logic [2:0] keys;
      repeat (3) @(negedge clk);
      check("rst_entry", 32'(entry_value), 0);
      check("rst_count", 32'(nibble_count), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_wr_en", 32'(wr_en), 0);
      check("rst_wr_addr", 32'(wr_addr), 0);
      check("rst_wr_data", 32'(wr_data), 0);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      // Bounce: short lows must never be accepted, final hold gives one LOAD.
      sw = 7'h06;
      for (int i = 0; i < 5; i++) begin
         key_n[0] = 1'b0;
         repeat (2) @(negedge clk);
         key_n[0] = 1'b1;
         repeat (2) @(negedge clk);
      end
      check("bounce_no_event", 32'(nibble_count), 0);
      key_n[0] = 1'b0;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (nibble_count != 3'd0) begin
            lat = i;
            break;
         end
      end
      check("bounce_latency", lat, 2 + DB + 1);
      model_press(3'b001, 4'h6, 3'd0);
      repeat (20) @(negedge clk);
      key_n[0] = 1'b1;
      repeat (10) @(negedge clk);
      $display("bounce latency=%0d entry=%h count=%0d", lat, entry_value, nibble_count);
      check_entry("bounce");

      // Entry with saturation at four nibbles.
      press(3'b100, 4'h0, 3'd0);
      press(3'b001, 4'hA, 3'd0);
      press(3'b001, 4'hB, 3'd0);
      press(3'b001, 4'hC, 3'd0);
      press(3'b001, 4'hD, 3'd0);
      press(3'b001, 4'h5, 3'd0);
      check("sat_entry_const", 32'(entry_value), 32'h0000BCD5);
      check("sat_count_const", 32'(nibble_count), 4);

      // Commit handshake with a 3-cycle ack delay.
      press(3'b100, 4'h0, 3'd0);
      press(3'b001, 4'h1, 3'd0);
      press(3'b001, 4'h2, 3'd0);
      ack_delay = 3;
      press(3'b010, 4'h0, 3'd5);
      check("commit_wr_en_low", 32'(wr_en), 0);

      // Empty commit, then CLEAR and COMMIT in the same cycle.
      press(3'b010, 4'h0, 3'd2);
      press(3'b001, 4'h7, 3'd0);
      press(3'b110, 4'h0, 3'd3);

      // Key presses while a write is pending are dropped.
      press(3'b001, 4'h4, 3'd0);
      ack_hold = 1'b1;
      press(3'b010, 4'h0, 3'd1);
      check("hold_wr_en", 32'(wr_en), 1);
      press(3'b001, 4'h9, 3'd0);
      press(3'b100, 4'h0, 3'd0);
      ack_delay = 0;
      ack_hold  = 1'b0;
      nib_q.delete();
      model_busy = 1'b0;
      repeat (8) @(negedge clk);
      check_entry("after_busy");
      check("after_busy_wr_en", 32'(wr_en), 0);

      // Reset while the request is held: everything drops asynchronously.
      press(3'b001, 4'h3, 3'd0);
      ack_hold = 1'b1;
      press(3'b010, 4'h0, 3'd6);
      check("pre_reset_wr_en", 32'(wr_en), 1);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("async_wr_en", 32'(wr_en), 0);
      check("async_busy", 32'(busy), 0);
      check("async_entry", 32'(entry_value), 0);
      check("async_count", 32'(nibble_count), 0);
      check("async_wr_addr", 32'(wr_addr), 0);
      check("async_wr_data", 32'(wr_data), 0);
      nib_q.delete();
      model_busy = 1'b0;
      ack_hold   = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      ack_force = 1'b1;
      @(negedge clk);
      ack_force = 1'b0;
      repeat (5) @(negedge clk);
      check("post_reset_wr_en", 32'(wr_en), 0);
      check("post_reset_busy", 32'(busy), 0);
      check_entry("post_reset");

      // Random key mix against the model.
      for (int i = 0; i < 40; i++) begin
         int r = $urandom_range(0, 9);
         if (r <= 5) keys = 3'b001;
         else if (r <= 7) keys = 3'b010;
         else if (r == 8) keys = 3'b100;
         else keys = 3'($urandom_range(1, 7));
         ack_delay = $urandom_range(0, 3);
         press(keys, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
      end

      check("scoreboard_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
